// File: rtl/conv_pkg.sv
// Shared helpers for the conv-layer output stage: default geometry, width derivation
// and signed saturation bounds.
package conv_pkg;

   localparam int DEF_N_OUT  = 16;
   localparam int DEF_N_IN   = 6;
   localparam int DEF_MAC_W  = 23;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_SHIFT  = 7;

   function automatic int clog2(input int value);
      int r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Width that holds the exact sum of n_in signed mac_w-bit partials.
   function automatic int sum_w(input int mac_w, input int n_in);
      return mac_w + clog2(n_in);
   endfunction

   function automatic int addr_w(input int n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/conv_exec_param_if.sv
// Stream + bias-write bundle of the conv output stage; slave is the block side,
// master the MAC-array / feature-map-port side.
interface conv_exec_param_if #(
   parameter int N_OUT  = conv_pkg::DEF_N_OUT,
   parameter int N_IN   = conv_pkg::DEF_N_IN,
   parameter int MAC_W  = conv_pkg::DEF_MAC_W,
   parameter int DATA_W = conv_pkg::DEF_DATA_W
);
   import conv_pkg::*;

   localparam int AW = addr_w(N_OUT);

   logic                          in_valid;
   logic                          in_ready;
   logic [N_OUT*N_IN*MAC_W-1:0]   mac_in;
   logic                          bias_we;
   logic [AW-1:0]                 bias_addr;
   logic [DATA_W-1:0]             bias_wdata;
   logic                          out_valid;
   logic                          out_ready;
   logic [N_OUT*DATA_W-1:0]       out_data;
   logic [N_OUT-1:0]              out_sat;

   modport slave (
      input  in_valid, mac_in, bias_we, bias_addr, bias_wdata, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, mac_in, bias_we, bias_addr, bias_wdata, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/conv_chan_sum.sv
// One output lane: pairwise adder tree, shift, bias add and saturation over three
// enabled stages. CONV_EXEC_RELU_EN clamps negative results to zero.
module conv_chan_sum
   import conv_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int MAC_W  = DEF_MAC_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SHIFT  = DEF_SHIFT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [N_IN*MAC_W-1:0]     mac,
   input  logic signed [DATA_W-1:0]  bias,
   output logic [DATA_W-1:0]         data_q,
   output logic                      sat_q
);

   localparam int NP     = (N_IN + 1) / 2;
   localparam int PAIR_W = MAC_W + 1;
   localparam int SUM_W  = sum_w(MAC_W, N_IN);
   localparam int ADD_W  = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;

   localparam logic signed [ADD_W-1:0] MAX_EXT = ADD_W'(sat_max(DATA_W));
   localparam logic signed [ADD_W-1:0] MIN_EXT = ADD_W'(sat_min(DATA_W));

   logic signed [MAC_W-1:0]  in_pad [2*NP];
   logic signed [PAIR_W-1:0] pair_q [NP];
   logic signed [PAIR_W-1:0] pair_d [NP];
   logic signed [SUM_W-1:0]  sum_acc;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  sum_d;
   logic signed [ADD_W-1:0]  biased;
   logic [DATA_W-1:0]        data_d;
   logic                     sat_d;

   // An odd input count pads the last pair with zero.
   for (genvar i = 0; i < 2*NP; i++) begin : g_pad
      if (i < N_IN) begin : g_in
         assign in_pad[i] = mac[i*MAC_W +: MAC_W];
      end else begin : g_zero
         assign in_pad[i] = '0;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pair_d = pair_q;
      if (en) begin
         for (int p = 0; p < NP; p++) begin
            pair_d[p] = PAIR_W'(in_pad[2*p]) + PAIR_W'(in_pad[2*p+1]);
         end
      end
   end

   always_comb begin
      sum_acc = '0;
      for (int p = 0; p < NP; p++) begin
         sum_acc = sum_acc + SUM_W'(pair_q[p]);
      end
      sum_d = en ? (sum_acc >>> SHIFT) : sum_q;
   end

   always_comb begin
      biased = ADD_W'(sum_q) + ADD_W'(bias);
      data_d = data_q;
      sat_d  = sat_q;
      if (en) begin
         if (biased > MAX_EXT) begin
            data_d = MAX_EXT[DATA_W-1:0];
            sat_d  = 1'b1;
         end else if (biased < MIN_EXT) begin
            data_d = MIN_EXT[DATA_W-1:0];
            sat_d  = 1'b1;
         end else begin
            data_d = biased[DATA_W-1:0];
            sat_d  = 1'b0;
         end
`ifdef CONV_EXEC_RELU_EN
         if (data_d[DATA_W-1]) begin
            data_d = '0;
            sat_d  = 1'b0;
         end
`endif
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NP; p++) pair_q[p] <= '0;
         sum_q  <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         pair_q <= pair_d;
         sum_q  <= sum_d;
         data_q <= data_d;
         sat_q  <= sat_d;
      end
   end

endmodule

// File: rtl/conv_exec_param.sv
// Conv-layer output stage top: bias register file, valid pipeline, stall control and
// N_OUT conv_chan_sum lanes. Build option CONV_EXEC_RELU_EN selects ReLU clamping.
module conv_exec_param
   import conv_pkg::*;
#(
   parameter int N_OUT  = DEF_N_OUT,
   parameter int N_IN   = DEF_N_IN,
   parameter int MAC_W  = DEF_MAC_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SHIFT  = DEF_SHIFT
) (
   input logic               clk,
   input logic               rst_n,
   conv_exec_param_if.slave  bus
);

   logic                     en;
   logic                     v1_q, v1_d;
   logic                     v2_q, v2_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] bias_q [N_OUT];
   logic signed [DATA_W-1:0] bias_d [N_OUT];
   logic [DATA_W-1:0]        lane_data [N_OUT];
   logic [N_OUT-1:0]         lane_sat;

   // The whole pipeline moves in lockstep; a full output register blocks all stages.
   assign en            = bus.out_ready | ~out_valid_q;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sat   = lane_sat;

   always_comb begin
      v1_d        = v1_q;
      v2_d        = v2_q;
      out_valid_d = out_valid_q;
      if (en) begin
         v1_d        = bus.in_valid;
         v2_d        = v1_q;
         out_valid_d = v2_q;
      end
   end

   // Writes ignore stalls; out-of-range lanes are dropped.
   always_comb begin
      bias_d = bias_q;
      if (bus.bias_we && (int'(bus.bias_addr) < N_OUT)) begin
         bias_d[bus.bias_addr] = bus.bias_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         // NOTE: the bias file is a small flop array, not RAM, so it is cleared by reset.
         for (int k = 0; k < N_OUT; k++) bias_q[k] <= '0;
      end else begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         out_valid_q <= out_valid_d;
         bias_q      <= bias_d;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      conv_chan_sum #(
         .N_IN   (N_IN),
         .MAC_W  (MAC_W),
         .DATA_W (DATA_W),
         .SHIFT  (SHIFT)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .mac    (bus.mac_in[k*N_IN*MAC_W +: N_IN*MAC_W]),
         .bias   (bias_q[k]),
         .data_q (lane_data[k]),
         .sat_q  (lane_sat[k])
      );
      assign bus.out_data[k*DATA_W +: DATA_W] = lane_data[k];
   end

endmodule

// File: tb/tb_conv_exec_param.sv
// Scoreboard bench for conv_exec_param: default geometry plus a small second instance
// driven with random beats and random backpressure.
module tb_conv_exec_param;

   localparam int A_OUT = 16, A_IN = 6, A_MW = 23, A_DW = 16, A_SH = 7;
   localparam int B_OUT = 4,  B_IN = 3, B_MW = 20, B_DW = 12, B_SH = 8;
   localparam int A_MACW = A_OUT*A_IN*A_MW;
   localparam int B_MACW = B_OUT*B_IN*B_MW;

`ifdef CONV_EXEC_RELU_EN
   localparam logic [15:0] NEG_SAT  = 16'h0000;
   localparam logic        NEG_FLAG = 1'b0;
`else
   localparam logic [15:0] NEG_SAT  = 16'h8000;
   localparam logic        NEG_FLAG = 1'b1;
`endif

   typedef struct {
      logic [255:0] d;
      logic [255:0] s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   conv_exec_param_if #(.N_OUT(A_OUT), .N_IN(A_IN), .MAC_W(A_MW), .DATA_W(A_DW)) bus_a ();
   conv_exec_param_if #(.N_OUT(B_OUT), .N_IN(B_IN), .MAC_W(B_MW), .DATA_W(B_DW)) bus_b ();

   conv_exec_param #(.N_OUT(A_OUT), .N_IN(A_IN), .MAC_W(A_MW), .DATA_W(A_DW), .SHIFT(A_SH))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   conv_exec_param #(.N_OUT(B_OUT), .N_IN(B_IN), .MAC_W(B_MW), .DATA_W(B_DW), .SHIFT(B_SH))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int           n_total = 0;
   int           n_bad   = 0;
   exp_t         q_a[$];
   exp_t         q_b[$];
   longint       mb_a[16];
   longint       mb_b[16];
   int           beats_a = 0;
   int           beats_b = 0;
   logic [255:0] last_d_a = '0;
   logic [255:0] prev_d_a = '0;
   logic [255:0] last_s_a = '0;
   bit           bp_a  = 1'b0;
   bit           rnd_b = 1'b0;

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer sum, floor shift, bias, clip, optional ReLU.
   function automatic exp_t ref_beat(input int n_out, input int n_in, input int mac_w,
                                     input int data_w, input int shift,
                                     input logic [A_MACW-1:0] mac, input longint bias[16]);
      exp_t e;
      longint acc, v, r, mx, mn;
      logic [A_MACW-1:0] sh;
      e.d = '0;
      e.s = '0;
      mx = (64'sd1 <<< (data_w - 1)) - 1;
      mn = -(64'sd1 <<< (data_w - 1));
      for (int k = 0; k < n_out; k++) begin
         acc = 0;
         for (int i = 0; i < n_in; i++) begin
            sh = mac >> ((k*n_in + i) * mac_w);
            v = longint'(sh[63:0]) & ((64'sd1 <<< mac_w) - 1);
            if (v >= (64'sd1 <<< (mac_w - 1))) v = v - (64'sd1 <<< mac_w);
            acc = acc + v;
         end
         r = (acc >>> shift) + bias[k];
         if (r > mx) begin
            r = mx;
            e.s[k] = 1'b1;
         end else if (r < mn) begin
            r = mn;
            e.s[k] = 1'b1;
         end
`ifdef CONV_EXEC_RELU_EN
         if (r < 0) begin
            r = 0;
            e.s[k] = 1'b0;
         end
`endif
         e.d = e.d | (256'(r & ((64'sd1 <<< data_w) - 1)) << (k*data_w));
      end
      return e;
   endfunction

   // Output monitors: pop on handshake, check hold-while-stalled and in_ready.
   initial begin
      exp_t e;
      bit stall = 1'b0;
      logic [255:0] hold = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("hold_v_a", bus_a.out_valid, 1'b1);
               check("hold_d_a", bus_a.out_data, hold);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
               if (q_a.size() == 0) begin
                  check("extra_a", q_a.size(), 1);
               end else begin
                  e = q_a.pop_front();
                  check("data_a", bus_a.out_data, e.d);
                  check("sat_a", bus_a.out_sat, e.s);
                  prev_d_a = last_d_a;
                  last_d_a = bus_a.out_data;
                  last_s_a = bus_a.out_sat;
                  beats_a++;
               end
            end
            stall = bus_a.out_valid && !bus_a.out_ready;
            if (stall) begin
               hold = bus_a.out_data;
               check("rdy_a", bus_a.in_ready, 1'b0);
            end
         end
      end
   end

   initial begin
      exp_t e;
      bit stall = 1'b0;
      logic [255:0] hold = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) check("hold_d_b", bus_b.out_data, hold);
            if (bus_b.out_valid && bus_b.out_ready) begin
               if (q_b.size() == 0) begin
                  check("extra_b", q_b.size(), 1);
               end else begin
                  e = q_b.pop_front();
                  check("data_b", bus_b.out_data, e.d);
                  check("sat_b", bus_b.out_sat, e.s);
                  beats_b++;
               end
            end
            stall = bus_b.out_valid && !bus_b.out_ready;
            if (stall) begin
               hold = bus_b.out_data;
               check("rdy_b", bus_b.in_ready, 1'b0);
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (bp_a)  bus_a.out_ready = ~bus_a.out_ready;
      if (rnd_b) bus_b.out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic send_a(input logic [A_MACW-1:0] mac);
      exp_t e;
      int guard = 0;
      e = ref_beat(A_OUT, A_IN, A_MW, A_DW, A_SH, mac, mb_a);
      bus_a.mac_in   = mac;
      bus_a.in_valid = 1'b1;
      @(negedge clk);
      while (!bus_a.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("accept_a", bus_a.in_ready, 1'b1);
      if (bus_a.in_ready) q_a.push_back(e);
      @(posedge clk);
      #1;
      bus_a.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [B_MACW-1:0] mac);
      exp_t e;
      int guard = 0;
      e = ref_beat(B_OUT, B_IN, B_MW, B_DW, B_SH, A_MACW'(mac), mb_b);
      bus_b.mac_in   = mac;
      bus_b.in_valid = 1'b1;
      @(negedge clk);
      while (!bus_b.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("accept_b", bus_b.in_ready, 1'b1);
      if (bus_b.in_ready) q_b.push_back(e);
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
   endtask

   task automatic write_bias_a(input int addr, input longint val);
      bus_a.bias_we    = 1'b1;
      bus_a.bias_addr  = 4'(addr);
      bus_a.bias_wdata = 16'(val);
      mb_a[addr]       = val;
      @(posedge clk);
      #1;
      bus_a.bias_we = 1'b0;
   endtask

   task automatic write_bias_b(input int addr, input longint val);
      bus_b.bias_we    = 1'b1;
      bus_b.bias_addr  = 2'(addr);
      bus_b.bias_wdata = 12'(val);
      mb_b[addr]       = val;
      @(posedge clk);
      #1;
      bus_b.bias_we = 1'b0;
   endtask

   task automatic drain_a();
      int g = 0;
      while (q_a.size() != 0 && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain_a", q_a.size(), 0);
   endtask

   task automatic drain_b();
      int g = 0;
      while (q_b.size() != 0 && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain_b", q_b.size(), 0);
   endtask

   function automatic logic [A_MACW-1:0] fill_a(input int lane, input logic [A_MW-1:0] val,
                                                input logic [A_MW-1:0] others);
      logic [A_MACW-1:0] m;
      m = '0;
      for (int k = 0; k < A_OUT; k++)
         for (int i = 0; i < A_IN; i++)
            m[(k*A_IN+i)*A_MW +: A_MW] = (k == lane) ? val : others;
      return m;
   endfunction

   initial begin
      logic [A_MACW-1:0] ma;
      logic [255:0]      rb;
      int lat;
      int b0;

      for (int k = 0; k < 16; k++) begin
         mb_a[k] = 0;
         mb_b[k] = 0;
      end
      bus_a.in_valid = 1'b0; bus_a.mac_in = '0; bus_a.bias_we = 1'b0;
      bus_a.bias_addr = '0;  bus_a.bias_wdata = '0; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.mac_in = '0; bus_b.bias_we = 1'b0;
      bus_b.bias_addr = '0;  bus_b.bias_wdata = '0; bus_b.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_a", bus_a.out_valid, 1'b0);
      check("rst_data_a", bus_a.out_data, '0);
      check("rst_sat_a", bus_a.out_sat, '0);
      check("rst_valid_b", bus_b.out_valid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic beat and latency
      write_bias_a(0, 16);
      ma = fill_a(0, 23'd128, 23'd128);
      send_a(ma);
      lat = 1;
      while (!bus_a.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, 3);
      check("lane0_basic", bus_a.out_data[15:0], 16'h0016);
      check("lane0_sat", bus_a.out_sat[0], 1'b0);
      drain_a();

      // Saturation both directions on lane 1
      send_a(fill_a(1, 23'h3FFFFF, 23'd128));
      drain_a();
      check("sat_pos", last_d_a[31:16], 16'h7FFF);
      check("sat_pos_flag", last_s_a[1], 1'b1);
      send_a(fill_a(1, 23'h400000, 23'd128));
      drain_a();
      check("sat_neg", last_d_a[31:16], NEG_SAT);
      check("sat_neg_flag", last_s_a[1], NEG_FLAG);

      // Backpressure with counting data
      b0 = beats_a;
      bp_a = 1'b1;
      for (int n = 0; n < 10; n++) begin
         for (int f = 0; f < A_OUT*A_IN; f++) ma[f*A_MW +: A_MW] = 23'(n*4096 + f*16 - 3000);
         send_a(ma);
      end
      drain_a();
      bp_a = 1'b0;
      bus_a.out_ready = 1'b1;
      check("bp_count", beats_a - b0, 10);

      // Bias write while beat A sits in S2; beat B sees the new value
      for (int f = 0; f < A_OUT*A_IN; f++) ma[f*A_MW +: A_MW] = 23'($urandom_range(0, 2000));
      send_a(ma);
      mb_a[2] = 256;
      send_a(ma);
      bus_a.bias_we = 1'b1; bus_a.bias_addr = 4'd2; bus_a.bias_wdata = 16'h0100;
      @(posedge clk);
      #1;
      bus_a.bias_we = 1'b0;
      drain_a();
      rb = last_d_a - prev_d_a;
      check("hazard_diff", rb[47:32], 16'h0100);
      check("hazard_other", last_d_a[31:0], prev_d_a[31:0]);

      // Reset mid-stream discards in-flight beats and clears biases
      write_bias_a(3, 500);
      write_bias_a(5, -7);
      for (int n = 0; n < 4; n++) send_a(fill_a(n, 23'(n*300), 23'd50));
      check("pre_rst_valid", bus_a.out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      q_a.delete();
      #1;
      check("mid_rst_valid", bus_a.out_valid, 1'b0);
      check("mid_rst_data", bus_a.out_data, '0);
      check("mid_rst_sat", bus_a.out_sat, '0);
      for (int k = 0; k < 16; k++) mb_a[k] = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_a(fill_a(0, 23'd128, 23'd128));
      drain_a();
      check("rst_bias0", last_d_a[15:0], 16'd6);
      check("rst_bias3", last_d_a[63:48], 16'd6);

      // Second geometry: random beats under random backpressure
      for (int k = 0; k < B_OUT; k++) write_bias_b(k, longint'($urandom_range(0, 4095)) - 2048);
      rnd_b = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         logic [255:0] r;
         for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
         send_b(r[B_MACW-1:0]);
      end
      rnd_b = 1'b0;
      bus_b.out_ready = 1'b1;
      drain_b();
      check("sweep_count", beats_b, 1000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
